// File: rtl/video_stream_tx.sv
// Frame-timed pixel transmitter: pulls pixels from a valid/ready source into a vsync/href raster.
// Optional build macro VIDEO_TX_TEST_PATTERN_EN adds a test_mode input driving an XOR test pattern.
module video_stream_tx #(
    parameter logic [10:0] IMG_HDISP  = 11'd640,
    parameter logic [10:0] IMG_VDISP  = 11'd480,
    parameter logic [10:0] H_BLANK    = 11'd160,
    parameter logic [10:0] V_LOW      = 11'd2,
    parameter logic [10:0] V_PRE      = 11'd20,
    parameter logic [10:0] V_POST     = 11'd20,
    parameter int          DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef VIDEO_TX_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic [DATA_WIDTH-1:0] post_img_data,
    output logic                  frame_done,
    output logic                  underflow
);

    typedef enum logic [2:0] {IDLE, VLOW, PRE, ACTIVE, POST} state_e;

    localparam logic [10:0] COL_LAST = H_BLANK + IMG_HDISP - 11'd1;

    function automatic logic [10:0] lines_of(input state_e s);
        case (s)
            VLOW:    lines_of = V_LOW;
            PRE:     lines_of = V_PRE;
            ACTIVE:  lines_of = IMG_VDISP;
            POST:    lines_of = V_POST;
            default: lines_of = 11'd0;
        endcase
    endfunction

    // First region at or after s (in frame order) that has a nonzero line count; IDLE if none.
    function automatic state_e first_from(input state_e s);
        state_e r;
        r = IDLE;
        if (s == VLOW && V_LOW != 11'd0)
            r = VLOW;
        else if ((s == VLOW || s == PRE) && V_PRE != 11'd0)
            r = PRE;
        else if (s != POST && s != IDLE && IMG_VDISP != 11'd0)
            r = ACTIVE;
        else if (s != IDLE && V_POST != 11'd0)
            r = POST;
        return r;
    endfunction

    function automatic state_e succ(input state_e s);
        case (s)
            VLOW:    succ = first_from(PRE);
            PRE:     succ = first_from(ACTIVE);
            ACTIVE:  succ = first_from(POST);
            default: succ = IDLE;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic [10:0]             col_q, col_d;
    logic [10:0]             line_q, line_d;
    logic                    vsync_q, href_q, done_q, uf_q;
    logic [DATA_WIDTH-1:0]   data_q;

    logic                    last_col_c, last_state_c, frame_end_c;
    logic                    act_win_c, ready_c;
    logic [DATA_WIDTH-1:0]   pix_c;

    assign last_col_c   = (col_q == COL_LAST);
    assign last_state_c = (state_q != IDLE) && last_col_c &&
                          (line_q == lines_of(state_q) - 11'd1);
    assign frame_end_c  = last_state_c && (succ(state_q) == IDLE);
    assign act_win_c    = (state_q == ACTIVE) && (col_q >= H_BLANK);

`ifdef VIDEO_TX_TEST_PATTERN_EN
    logic [10:0] pattern_c;
    assign pattern_c = (col_q - H_BLANK) ^ line_q;
    assign ready_c   = act_win_c && !test_mode && !rst;
    always_comb begin
        pix_c = '0;
        if (test_mode) begin
            if (act_win_c)
                pix_c = DATA_WIDTH'(pattern_c);
        end else if (ready_c && src_valid) begin
            pix_c = src_data;
        end
    end
`else
    assign ready_c = act_win_c && !rst;
    always_comb begin
        pix_c = '0;
        if (ready_c && src_valid)
            pix_c = src_data;
    end
`endif

    assign src_ready = ready_c;

    // Counters restart at every region entry; enable only matters in IDLE and at frame end.
    always_comb begin
        state_d = state_q;
        col_d   = 11'd0;
        line_d  = 11'd0;
        if (state_q == IDLE) begin
            if (enable)
                state_d = first_from(VLOW);
        end else if (last_state_c) begin
            if (frame_end_c)
                state_d = enable ? first_from(VLOW) : IDLE;
            else
                state_d = succ(state_q);
        end else if (last_col_c) begin
            line_d = line_q + 11'd1;
        end else begin
            col_d  = col_q + 11'd1;
            line_d = line_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 11'd0;
            line_q  <= 11'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            vsync_q <= (state_q == PRE) || (state_q == ACTIVE) || (state_q == POST);
            href_q  <= act_win_c;
            data_q  <= pix_c;
            done_q  <= frame_end_c;
            uf_q    <= uf_q | (ready_c & ~src_valid);
        end
    end

    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;
    assign post_img_data    = data_q;
    assign frame_done       = done_q;
    assign underflow        = uf_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Self-checking bench for video_stream_tx: frame-position reference model plus scenario tasks.
module tb_video_stream_tx;

    localparam int DW    = 8;
    localparam int HD    = 4;
    localparam int VD    = 2;
    localparam int HB    = 2;
    localparam int VL    = 1;
    localparam int VP    = 1;
    localparam int VPO   = 1;
    localparam int LINE  = HB + HD;
    localparam int FRAME = LINE * (VL + VP + VD + VPO);
    localparam int ACT0  = VL + VP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          src_valid = 1'b0;
    logic          tm = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready, post_frame_vsync, post_frame_href, frame_done, underflow;
    logic [DW-1:0] post_img_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    video_stream_tx #(
        .IMG_HDISP(11'd4), .IMG_VDISP(11'd2), .H_BLANK(11'd2),
        .V_LOW(11'd1), .V_PRE(11'd1), .V_POST(11'd1), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef VIDEO_TX_TEST_PATTERN_EN
        .test_mode(tm),
`endif
        .enable(enable),
        .src_data(src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href(post_frame_href),
        .post_img_data(post_img_data),
        .frame_done(frame_done),
        .underflow(underflow)
    );

    // Reference model: a frame is FRAME cycles indexed by position; outputs lag one cycle.
    logic          m_run;
    int            m_pos;
    int            m_line, m_col;
    logic          m_act, m_rdy;
    logic          exp_vs, exp_hr, exp_fd, exp_uf;
    logic [DW-1:0] exp_dat;

    always_comb begin
        m_line = m_pos / LINE;
        m_col  = m_pos % LINE;
        m_act  = m_run && (m_line >= ACT0) && (m_line < ACT0 + VD) && (m_col >= HB);
        m_rdy  = !rst && m_act && !tm;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_run   <= 1'b0;
            m_pos   <= 0;
            exp_vs  <= 1'b0;
            exp_hr  <= 1'b0;
            exp_dat <= '0;
            exp_fd  <= 1'b0;
            exp_uf  <= 1'b0;
        end else begin
            exp_vs <= m_run && (m_line >= VL);
            exp_hr <= m_act;
            if (tm && m_act)
                exp_dat <= DW'((m_col - HB) ^ (m_line - ACT0));
            else if (m_rdy && src_valid)
                exp_dat <= src_data;
            else
                exp_dat <= '0;
            exp_uf <= exp_uf | (m_rdy && !src_valid);
            exp_fd <= m_run && (m_pos == FRAME - 1);
            if (!m_run || m_pos == FRAME - 1) begin
                m_run <= enable;
                m_pos <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    wire [DW+4:0] obs  = {post_frame_vsync, post_frame_href, post_img_data, frame_done, underflow, src_ready};
    wire [DW+4:0] expv = {exp_vs, exp_hr, exp_dat, exp_fd, exp_uf, m_rdy};

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; src_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs actual=%h required=0", obs);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== '0 || obs !== expv) begin
            errors++;
            $display("FAIL idle_outputs actual=%h required=%h", obs, expv);
        end
    endtask

    task automatic test_stream();
        logic          vs_a[80];
        logic          hr_a[80];
        logic          fd_a[80];
        logic [DW-1:0] d_a[80];
        int cnt, f1, f2, k, low_ok, high_cnt;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        cnt = 0; enable = 1'b1; src_valid = 1'b1; src_data = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL stream_model cyc=%0d actual=%h required=%h", c, obs, expv);
            end
            vs_a[c] = post_frame_vsync; hr_a[c] = post_frame_href;
            fd_a[c] = frame_done;       d_a[c]  = post_img_data;
            src_data = cnt[DW-1:0];
            if (src_ready) cnt++;
        end
        f1 = -1; f2 = -1;
        for (int c = 0; c < 80; c++)
            if (fd_a[c]) begin
                if (f1 < 0) f1 = c; else if (f2 < 0) f2 = c;
            end
        checks++;
        if (f1 != 30 || f2 != 60) begin
            errors++;
            $display("FAIL frame_done_period actual=%0d,%0d required=30,60", f1, f2);
        end
        if (f1 >= 0 && f2 > f1 && f2 < 80) begin
            low_ok = 0; high_cnt = 0;
            for (int c = f1 + 1; c <= f2; c++) begin
                if (c <= f1 + 6 && !vs_a[c]) low_ok++;
                if (vs_a[c]) high_cnt++;
            end
            checks++;
            if (low_ok != 6 || high_cnt != 24) begin
                errors++;
                $display("FAIL vsync_shape actual=low%0d/high%0d required=low6/high24", low_ok, high_cnt);
            end
            k = 0;
            for (int c = 0; c <= f2; c++)
                if (hr_a[c]) begin
                    checks++;
                    if (d_a[c] !== DW'(k)) begin
                        errors++;
                        $display("FAIL stream_pixel idx=%0d actual=%0d required=%0d", k, d_a[c], k);
                    end
                    k++;
                end
            checks++;
            if (k != 16) begin
                errors++;
                $display("FAIL stream_pixel_count actual=%0d required=16", k);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_underflow();
        int nrdy, stall;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        enable = 1'b1; src_valid = 1'b1; nrdy = 0; stall = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL underflow_model cyc=%0d actual=%h required=%h", c, obs, expv);
            end
            if (stall >= 0 && c == stall + 1) begin
                checks++;
                if ({post_frame_href, post_img_data, underflow} !== {1'b1, {DW{1'b0}}, 1'b1}) begin
                    errors++;
                    $display("FAIL underflow_slot actual=%b/%h/%b required=1/00/1",
                             post_frame_href, post_img_data, underflow);
                end
            end
            src_data = DW'($urandom);
            src_valid = 1'b1;
            if (src_ready) begin
                if (nrdy == 1) begin
                    checks++;
                    if (underflow !== 1'b0) begin
                        errors++;
                        $display("FAIL underflow_early actual=%b required=0", underflow);
                    end
                end
                nrdy++;
                if (nrdy == 2) begin src_valid = 1'b0; stall = c; end
            end
        end
        checks++;
        if (underflow !== 1'b1 || stall < 0) begin
            errors++;
            $display("FAIL underflow_sticky actual=%b required=1", underflow);
        end
        enable = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear actual=%b required=0", underflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_enable_drop();
        int   done_at, bad_after;
        logic dropped;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        enable = 1'b1; src_valid = 1'b1; dropped = 1'b0; done_at = -1; bad_after = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL drop_model cyc=%0d actual=%h required=%h", c, obs, expv);
            end
            if (done_at >= 0 && (post_frame_vsync || post_frame_href || frame_done)) bad_after++;
            if (frame_done && done_at < 0) done_at = c;
            if (!dropped && src_ready) begin enable = 1'b0; dropped = 1'b1; end
            src_data = DW'($urandom);
        end
        checks++;
        if (!dropped || done_at < 0 || bad_after != 0) begin
            errors++;
            $display("FAIL enable_drop actual=done%0d/bad%0d required=done>=0/bad0", done_at, bad_after);
        end
    endtask

    task automatic test_reset_mid();
        int   n, lat;
        logic hit, found;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        enable = 1'b1; src_valid = 1'b1; n = 0; hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rstmid_model cyc=%0d actual=%h required=%h", c, obs, expv);
            end
            src_data = DW'($urandom);
            if (src_ready) begin
                n++;
                if (n == 3) begin rst = 1'b1; hit = 1'b1; end
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rstmid_timeout actual=%0d required=3", n);
        end
        #1;
        checks++;
        if (src_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready actual=%b required=0", src_ready);
        end
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs actual=%h required=0", obs);
        end
        rst = 1'b0; lat = 0; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            lat++;
            if (post_frame_vsync) found = 1'b1;
        end
        checks++;
        if (!found || lat != 8) begin
            errors++;
            $display("FAIL rstmid_restart actual=%0d required=8", lat);
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random_model cyc=%0d actual=%h required=%h", c, obs, expv);
            end
            src_data  = DW'($urandom);
            src_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) enable = !enable;
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0; enable = 1'b0;
    endtask

`ifdef VIDEO_TX_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [DW-1:0] want[8];
        int k, rdy_seen;
        want = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd0, 8'd3, 8'd2};
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        tm = 1'b1; enable = 1'b1; k = 0; rdy_seen = 0;
        for (int c = 0; c < 31; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL pattern_model cyc=%0d actual=%h required=%h", c, obs, expv);
            end
            if (src_ready) rdy_seen++;
            if (post_frame_href && k < 8) begin
                checks++;
                if (post_img_data !== want[k]) begin
                    errors++;
                    $display("FAIL pattern_pixel idx=%0d actual=%0d required=%0d", k, post_img_data, want[k]);
                end
                k++;
            end
            src_valid = $urandom_range(0, 1) != 0;
            src_data  = DW'($urandom);
        end
        checks++;
        if (k != 8 || rdy_seen != 0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL pattern_summary actual=pix%0d/rdy%0d/uf%b required=pix8/rdy0/uf0", k, rdy_seen, underflow);
        end
        tm = 1'b0; enable = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_underflow();
        test_enable_drop();
        test_reset_mid();
        test_random();
`ifdef VIDEO_TX_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_stream_tx.md
VIDEO_STREAM_TX -- requirements
Module: video_stream_tx

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 11'd640, meaning active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 11'd480, meaning active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 11'd160, meaning href-low cycles preceding each line's active pixels.
REQ-004 SHALL have parameters V_LOW, V_PRE, V_POST (defaults 11'd2, 11'd20, 11'd20), meaning line counts of the vsync-low, pre-active and post-active regions.
REQ-005 SHALL have parameter DATA_WIDTH, default 8, meaning pixel width.
REQ-006 SHALL have ports: clk  in  1  pixel clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: enable  in  1  run frames; src_data  in  DATA_WIDTH  upstream pixel; src_valid  in  1  pixel available; src_ready  out  1  pixel consumed this cycle.
REQ-008 SHALL have ports: post_frame_vsync  out  1  frame valid; post_frame_href  out  1  line valid; post_img_data  out  DATA_WIDTH  pixel; frame_done  out  1  one-cycle end-of-frame pulse; underflow  out  1  sticky starvation flag.

Function
REQ-009 SHALL use one clock domain (clk); reset is synchronous and active-high (rst).
REQ-010 SHALL implement FSM IDLE -> VLOW -> PRE -> ACTIVE -> POST -> (VLOW if enable else IDLE).
REQ-011 SHALL leave IDLE on the cycle after enable sampled high; enable is sampled only in IDLE and at the last cycle of POST.
REQ-012 SHALL define every line in every non-IDLE state as H_BLANK+IMG_HDISP cycles, counted by an 11-bit column counter wrapping to 0, and an 11-bit line counter reset at each state entry.
REQ-013 SHALL drive vsync 0 in IDLE/VLOW and 1 in PRE/ACTIVE/POST.
REQ-014 SHALL, in ACTIVE, assert src_ready combinationally for column counter values H_BLANK..H_BLANK+IMG_HDISP-1, otherwise 0; src_ready is 0 in all other states.
REQ-015 SHALL register outputs with fixed 1-cycle latency: href(t+1)=src_ready(t); data(t+1)=src_data(t) if src_ready&src_valid else 0.
REQ-016 SHALL never stall timing: src_ready&!src_valid sets underflow, outputs data 0 with href still 1.
REQ-017 SHALL clear underflow only by reset; drive post_img_data 0 whenever href is 0.
REQ-018 SHALL pulse frame_done for exactly one cycle, aligned with the registered output of the last POST cycle.
REQ-019 SHALL, when enable falls mid-frame, complete the current frame, then enter IDLE.
REQ-020 SHALL treat V_LOW/V_PRE/V_POST = 0 as skipping that state.

Reset
REQ-021 SHALL, on rst high at a clk edge, set state IDLE, counters 0, and vsync, href, data, frame_done, underflow to 0 from the next cycle, including mid-line.
REQ-022 SHALL hold src_ready 0 while rst is high.

Configuration
REQ-023 SHALL, with VIDEO_TX_TEST_PATTERN_EN defined, add input test_mode (1 bit): when high, src_ready stays 0, active pixel = (active column index XOR active line index) truncated to DATA_WIDTH, underflow is not set.
REQ-024 SHALL, without VIDEO_TX_TEST_PATTERN_EN, omit test_mode entirely and behave per REQ-014..016.

Verification (IMG_HDISP=4, IMG_VDISP=2, H_BLANK=2, V_LOW=1, V_PRE=1, V_POST=1; line=6 cycles)
REQ-025 SHALL cover: enable held 1, src_valid 1, src_data counting 0.. -> vsync low 6 cycles, high 24; href high 4 cycles after 2 low in each ACTIVE line; data 0,1,2,3 then 4,5,6,7; frame_done once per 30 cycles.
REQ-026 SHALL cover: src_valid 0 for the 2nd active pixel -> data 0 with href 1, underflow 1 until rst, timing unchanged.
REQ-027 SHALL cover: enable dropped during ACTIVE line 0 -> frame finishes, frame_done pulses, FSM IDLE, vsync stays 0.
REQ-028 SHALL cover: rst asserted on the 3rd active pixel -> next cycle all outputs 0, src_ready 0; after release, first vsync after enable+6 cycles.
REQ-029 SHALL cover (macro defined): test_mode 1 -> line 0 data 0,1,2,3; line 1 data 1,0,3,2; src_ready never 1.
